bsg_lru_pseudo_tree_tracker: RTL and testbench

Stateful tree pseudo-LRU tracker for a set-associative structure with `sets_p` sets and `ways_p` ways. It holds one `ways_p-1`-bit tree per set and updates the path bits of each touched way so that they point away from it. It returns a registered victim way per query and can optionally allocate (touch) that victim in the same operation. It sits beside the tag array of a cache or TLB. It is the update (decode) side paired with `bsg_lru_pseudo_tree_encode`, which it instantiates for victim selection.

---
 rtl/bsg_lru_pseudo_tree_tracker_pkg.sv | 9 +
 rtl/bsg_lru_pseudo_tree_decode.sv | 26 ++
 rtl/bsg_lru_pseudo_tree_encode.sv | 26 ++
 rtl/bsg_lru_pseudo_tree_tracker.sv | 78 +++++++
 tb/tb_bsg_lru_pseudo_tree_tracker.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/bsg_lru_pseudo_tree_tracker_pkg.sv
// Shared helpers for the pseudo-LRU tree tracker slice.
package bsg_lru_pseudo_tree_tracker_pkg;

    // Index width that never collapses to zero for single-entry structures.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_lru_pseudo_tree_decode.sv
// Way id -> path bits pointing away from that way, plus a mask of the path nodes.
module bsg_lru_pseudo_tree_decode
    import bsg_lru_pseudo_tree_tracker_pkg::*;
#(
    parameter int ways_p = 8,
    localparam int lg_ways_lp = safe_clog2(ways_p)
) (
    input  logic [lg_ways_lp-1:0] way_id_i,
    output logic [ways_p-2:0]     data_o,
    output logic [ways_p-2:0]     mask_o
);

    for (genvar l = 0; l < lg_ways_lp; l++) begin : lvl
        for (genvar j = 0; j < (1 << l); j++) begin : node
            localparam int n_lp = (1 << l) - 1 + j;
            // A 0 way bit at this level means the way sits in the left subtree.
            assign data_o[n_lp] = ~way_id_i[lg_ways_lp-1-l];
            if (l == 0) begin : root
                assign mask_o[n_lp] = 1'b1;
            end else begin : inner
                assign mask_o[n_lp] = (int'(way_id_i[lg_ways_lp-1 -: l]) == j);
            end
        end
    end

endmodule

// File: rtl/bsg_lru_pseudo_tree_encode.sv
// Tree bits -> LRU way, descending from the root one level at a time.
module bsg_lru_pseudo_tree_encode
    import bsg_lru_pseudo_tree_tracker_pkg::*;
#(
    parameter int ways_p = 8,
    localparam int lg_ways_lp = safe_clog2(ways_p)
) (
    input  logic [ways_p-2:0]     lru_i,
    output logic [lg_ways_lp-1:0] way_id_o
);

    // Each level's row of node bits is indexed by the way prefix chosen so far.
    for (genvar l = 0; l < lg_ways_lp; l++) begin : lvl
        logic [l:0]          p;
        logic [(1<<l)-1:0]   row;
        assign row = lru_i[(1 << l) - 1 +: (1 << l)];
        if (l == 0) begin : root
            assign p = row;
        end else begin : inner
            assign p = {lvl[l-1].p, row[lvl[l-1].p]};
        end
    end

    assign way_id_o = lvl[lg_ways_lp-1].p;

endmodule

// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// Per-set tree pseudo-LRU state with touch updates, same-cycle bypassed victim query and optional alloc.
module bsg_lru_pseudo_tree_tracker
    import bsg_lru_pseudo_tree_tracker_pkg::*;
#(
    parameter int sets_p = 64,
    parameter int ways_p = 8,
    localparam int lg_sets_lp = safe_clog2(sets_p),
    localparam int lg_ways_lp = safe_clog2(ways_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  touch_v_i,
    input  logic [lg_sets_lp-1:0] touch_set_i,
    input  logic [lg_ways_lp-1:0] touch_way_i,
    input  logic                  query_v_i,
    input  logic [lg_sets_lp-1:0] query_set_i,
    input  logic                  query_alloc_i,
    output logic                  victim_v_o,
    output logic [lg_ways_lp-1:0] victim_way_o
);

    logic [ways_p-2:0]     tree_r [sets_p];
    logic [ways_p-2:0]     tree_n [sets_p];
    logic [ways_p-2:0]     touch_data, touch_mask, alloc_data, alloc_mask, query_tree;
    logic [lg_ways_lp-1:0] victim_way;
    logic                  touch_ok, query_ok, touch_en, alloc_en;

    assign touch_ok = int'(touch_set_i) < sets_p;
    assign query_ok = int'(query_set_i) < sets_p;
    assign touch_en = touch_v_i & touch_ok;
    assign alloc_en = query_v_i & query_ok & query_alloc_i;

    bsg_lru_pseudo_tree_decode #(.ways_p(ways_p)) touch_dec (
        .way_id_i(touch_way_i), .data_o(touch_data), .mask_o(touch_mask)
    );

    // Query sees the touch of the same cycle; out-of-range sets read as all-zero (way 0).
    always_comb begin
        query_tree = '0;
        if (query_ok) begin
            query_tree = tree_r[query_set_i];
            if (touch_en && touch_set_i == query_set_i)
                query_tree = (query_tree & ~touch_mask) | (touch_data & touch_mask);
        end
    end

    bsg_lru_pseudo_tree_encode #(.ways_p(ways_p)) enc (
        .lru_i(query_tree), .way_id_o(victim_way)
    );

    bsg_lru_pseudo_tree_decode #(.ways_p(ways_p)) alloc_dec (
        .way_id_i(victim_way), .data_o(alloc_data), .mask_o(alloc_mask)
    );

    // Alloc lands on top of the touch so it wins on shared path nodes.
    always_comb begin
        for (int s = 0; s < sets_p; s++) begin
            tree_n[s] = tree_r[s];
            if (touch_en && int'(touch_set_i) == s)
                tree_n[s] = (tree_n[s] & ~touch_mask) | (touch_data & touch_mask);
            if (alloc_en && int'(query_set_i) == s)
                tree_n[s] = (tree_n[s] & ~alloc_mask) | (alloc_data & alloc_mask);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < sets_p; s++) tree_r[s] <= '0;
            victim_v_o   <= 1'b0;
            victim_way_o <= '0;
        end else begin
            tree_r     <= tree_n;
            victim_v_o <= query_v_i;
            if (query_v_i) victim_way_o <= victim_way;
        end
    end

endmodule

// File: tb/tb_bsg_lru_pseudo_tree_tracker.sv
// Scoreboard bench for the pseudo-LRU tracker: directed cases plus a random phase against a reference model.
module tb_bsg_lru_pseudo_tree_tracker;
    localparam int SETS = 4;
    localparam int WAYS = 8;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       touch_v_i = 1'b0;
    logic [1:0] touch_set_i = '0;
    logic [2:0] touch_way_i = '0;
    logic       query_v_i = 1'b0;
    logic [1:0] query_set_i = '0;
    logic       query_alloc_i = 1'b0;
    logic       victim_v_o;
    logic [2:0] victim_way_o;

    bsg_lru_pseudo_tree_tracker #(.sets_p(SETS), .ways_p(WAYS)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .touch_v_i(touch_v_i), .touch_set_i(touch_set_i), .touch_way_i(touch_way_i),
        .query_v_i(query_v_i), .query_set_i(query_set_i), .query_alloc_i(query_alloc_i),
        .victim_v_o(victim_v_o), .victim_way_o(victim_way_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_chk = 0;
    int         n_pass = 0;
    int         exp_q[$];
    logic [6:0] tree_m [SETS];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference: walk node indices explicitly.
    function automatic int m_enc(input logic [6:0] t);
        int n = 0;
        int w = 0;
        for (int l = 0; l < 3; l++) begin
            int b;
            b = int'(t[n]);
            w = w * 2 + b;
            n = 2 * n + 1 + b;
        end
        return w;
    endfunction

    function automatic logic [6:0] m_touch(input logic [6:0] t, input int w);
        int n = 0;
        for (int l = 2; l >= 0; l--) begin
            int b;
            b = (w >> l) & 1;
            t[n] = (b == 0);
            n = 2 * n + 1 + b;
        end
        return t;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) tree_m[i] = '0;
        exp_q.delete();
    endtask

    // One cycle: drive, update model, push expectation, then check after the edge.
    task automatic step(input string tag, input bit tv, input int ts, input int tw,
                        input bit qv, input int qs, input bit qa, input int exp_way);
        logic [6:0] tq;
        int vic;
        touch_v_i = tv; touch_set_i = 2'(ts); touch_way_i = 3'(tw);
        query_v_i = qv; query_set_i = 2'(qs); query_alloc_i = qa;
        tq = tree_m[qs];
        if (tv && ts == qs) tq = m_touch(tq, tw);
        vic = m_enc(tq);
        if (tv) tree_m[ts] = m_touch(tree_m[ts], tw);
        if (qv && qa) tree_m[qs] = m_touch(tree_m[qs], vic);
        if (qv) exp_q.push_back((exp_way >= 0) ? exp_way : vic);
        @(posedge clk_i); #1;
        touch_v_i = 1'b0; query_v_i = 1'b0; query_alloc_i = 1'b0;
        chk({tag, "_vld"}, int'(victim_v_o), int'(qv));
        if (victim_v_o && exp_q.size() > 0) chk({tag, "_way"}, int'(victim_way_o), exp_q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        #1;
        chk("rst_vld", int'(victim_v_o), 0);
        chk("rst_way", int'(victim_way_o), 0);
        model_clear();
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        model_clear();
        do_reset();

        step("q_rst", 0, 0, 0, 1, 2, 0, 0);
        step("idle", 0, 0, 0, 0, 0, 0, -1);

        step("t_s1w0", 1, 1, 0, 0, 0, 0, -1);
        step("q_s1", 0, 0, 0, 1, 1, 0, 4);
        step("q_s0", 0, 0, 0, 1, 0, 0, 0);

        for (int w = 0; w < WAYS; w++) step("t_s0_seq", 1, 0, w, 0, 0, 0, -1);
        step("q_s0_seq", 0, 0, 0, 1, 0, 0, 0);
        step("t_s0w0", 1, 0, 0, 0, 0, 0, -1);
        step("q_s0_w0", 0, 0, 0, 1, 0, 0, 4);

        do_reset();
        step("byp_other", 1, 2, 0, 1, 3, 0, 0);
        step("byp_same", 1, 3, 0, 1, 3, 0, 4);

        do_reset();
        step("alloc0", 0, 0, 0, 1, 2, 1, 0);
        step("alloc1", 0, 0, 0, 1, 2, 1, 4);
        step("alloc2", 0, 0, 0, 1, 2, 1, 2);

        for (int i = 0; i < 300; i++)
            step("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, SETS-1)),
                 int'($urandom_range(0, WAYS-1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, SETS-1)), 1'($urandom_range(0, 1)), -1);

        do_reset();
        step("t_pre", 1, 1, 0, 0, 0, 0, -1);
        step("q_pre", 0, 0, 0, 1, 1, 0, 4);
        #2 reset_n_i = 1'b0;
        #1;
        chk("mid_rst_vld", int'(victim_v_o), 0);
        chk("mid_rst_way", int'(victim_way_o), 0);
        model_clear();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step("q_post", 0, 0, 0, 1, 1, 0, 0);
        step("idle_post", 0, 0, 0, 0, 0, 0, -1);

        chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
